// File: rtl/physics_step_scheduler.sv
// Tick-driven sequencer that starts N particle engines one at a time on a shared datapath,
// then strobes snap_en so downstream logic latches a consistent frame.
`timescale 1ns/1ps
module physics_step_scheduler #(
  parameter int N_PARTICLES  = 3,
  parameter int TICK_PERIOD  = 1000000,
  parameter int STEP_TIMEOUT = 64,
  parameter int IDX_W        = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear_flags,
  input  logic [N_PARTICLES-1:0] step_done,
  output logic [N_PARTICLES-1:0] step_start,
  output logic [IDX_W-1:0]       active_idx,
  output logic                   busy,
  output logic                   snap_en,
  output logic [15:0]            frame_count,
  output logic                   overrun,
  output logic [N_PARTICLES-1:0] timeout_flags
);

  typedef enum logic [2:0] {IDLE, WAIT, START, RUN, SNAP} state_t;

  localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int WD_W   = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(STEP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_PARTICLES - 1);

  state_t                   state;
  logic [TICK_W-1:0]        tick_cnt;
  logic [WD_W-1:0]          watchdog;
  logic                     tick_expiring;
  logic                     done_hit;
  logic                     wd_expired;
  logic                     set_overrun;
  logic [IDX_W-1:0]         idx_next;
  logic [N_PARTICLES-1:0]   idx_mask;
  logic [N_PARTICLES-1:0]   next_mask;
  logic [N_PARTICLES-1:0]   set_timeout;

  // Only the engine currently running may complete its step; other done bits are ignored.
  assign idx_mask      = N_PARTICLES'(1) << active_idx;
  assign idx_next      = active_idx + IDX_W'(1);
  assign next_mask     = N_PARTICLES'(1) << idx_next;
  assign done_hit      = |(step_done & idx_mask);
  assign wd_expired    = (watchdog == WD_LAST);
  assign tick_expiring = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign set_overrun   = tick_expiring && (state inside {START, RUN, SNAP});
  assign set_timeout   = (state == RUN && !done_hit && wd_expired) ? idx_mask : '0;
  assign busy          = (state inside {START, RUN, SNAP});

  // reset_n is expected to be released synchronously to clk by the reset distribution.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      watchdog      <= '0;
      active_idx    <= '0;
      step_start    <= '0;
      snap_en       <= 1'b0;
      frame_count   <= '0;
      overrun       <= 1'b0;
      timeout_flags <= '0;
    end else begin
      step_start <= '0;
      snap_en    <= 1'b0;

      if (state == IDLE || tick_expiring) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      // Sticky flags: a coincident set beats clear_flags.
      overrun       <= set_overrun | (overrun & ~clear_flags);
      timeout_flags <= set_timeout | (timeout_flags & ~{N_PARTICLES{clear_flags}});

      case (state)
        IDLE: begin
          if (enable) state <= WAIT;
        end
        WAIT: begin
          if (!enable) begin
            state    <= IDLE;
            tick_cnt <= '0;
          end else if (tick_expiring) begin
            state      <= START;
            active_idx <= '0;
            step_start <= N_PARTICLES'(1);
          end
        end
        START: begin
          watchdog <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (done_hit || wd_expired) begin
            if (active_idx == IDX_LAST) begin
              state       <= SNAP;
              active_idx  <= '0;
              snap_en     <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state      <= START;
              active_idx <= idx_next;
              step_start <= next_mask;
            end
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        SNAP: begin
          state <= WAIT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Directed bench: one scheduler with TICK_PERIOD=100 for most scenarios, a second with
// TICK_PERIOD=20 for overrun; engine models return done a programmable number of cycles after start.
`timescale 1ns/1ps
module tb_physics_step_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_flags = 1'b0;
  logic [2:0]  eng_done = '0;
  logic [2:0]  stray_done = '0;
  logic [2:0]  step_done;
  logic [2:0]  step_start;
  logic [1:0]  active_idx;
  logic        busy, snap_en, overrun;
  logic [15:0] frame_count;
  logic [2:0]  timeout_flags;

  logic        ov_enable = 1'b0;
  logic        ov_clear = 1'b0;
  logic [2:0]  ov_done = '0;
  logic [2:0]  ov_step_start;
  logic [1:0]  ov_active_idx;
  logic        ov_busy, ov_snap_en, ov_overrun;
  logic [15:0] ov_frame_count;
  logic [2:0]  ov_timeout_flags;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int delay [3] = '{5, 5, 5};
  int cnt [3] = '{0, 0, 0};
  int ov_cnt [3] = '{0, 0, 0};
  int         st_cyc [$];
  logic [2:0] st_val [$];
  logic [1:0] st_idx [$];
  int         sn_cyc [$];
  int         ov_st_cyc [$];
  int         ov_sn_cyc [$];

  assign step_done = eng_done | stray_done;

  physics_step_scheduler #(.N_PARTICLES(3), .TICK_PERIOD(100), .STEP_TIMEOUT(64), .IDX_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_flags(clear_flags),
    .step_done(step_done), .step_start(step_start), .active_idx(active_idx), .busy(busy),
    .snap_en(snap_en), .frame_count(frame_count), .overrun(overrun), .timeout_flags(timeout_flags)
  );

  physics_step_scheduler #(.N_PARTICLES(3), .TICK_PERIOD(20), .STEP_TIMEOUT(64), .IDX_W(2)) dut_ov (
    .clk(clk), .reset_n(reset_n), .enable(ov_enable), .clear_flags(ov_clear),
    .step_done(ov_done), .step_start(ov_step_start), .active_idx(ov_active_idx), .busy(ov_busy),
    .snap_en(ov_snap_en), .frame_count(ov_frame_count), .overrun(ov_overrun),
    .timeout_flags(ov_timeout_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: done pulses delay[i] cycles after the start cycle; delay 0 means never.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      eng_done[i] = 1'b0;
      ov_done[i]  = 1'b0;
      if (!reset_n) begin
        cnt[i]    = 0;
        ov_cnt[i] = 0;
      end else begin
        if (step_start[i]) cnt[i] = delay[i];
        else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) eng_done[i] = 1'b1;
        end
        if (ov_step_start[i]) ov_cnt[i] = 10;
        else if (ov_cnt[i] > 0) begin
          ov_cnt[i]--;
          if (ov_cnt[i] == 0) ov_done[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (step_start != 3'b000) begin
      st_cyc.push_back(cyc);
      st_val.push_back(step_start);
      st_idx.push_back(active_idx);
    end
    if (snap_en) sn_cyc.push_back(cyc);
    if (ov_step_start[0]) ov_st_cyc.push_back(cyc);
    if (ov_snap_en) ov_sn_cyc.push_back(cyc);
  end

  task automatic run_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    ov_enable = 1'b0;
    clear_flags = 1'b0;
    stray_done = '0;
    repeat (2) @(negedge clk);
    st_cyc.delete();
    st_val.delete();
    st_idx.delete();
    sn_cyc.delete();
    ov_st_cyc.delete();
    ov_sn_cyc.delete();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int c0;
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (step_start !== 3'b000) begin errors++; $display("FAIL reset_step_start got %b want 000", step_start); end
    checks++; if (active_idx !== 2'd0) begin errors++; $display("FAIL reset_active_idx got %0d want 0", active_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (snap_en !== 1'b0) begin errors++; $display("FAIL reset_snap_en got %b want 0", snap_en); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (timeout_flags !== 3'b000) begin errors++; $display("FAIL reset_timeout_flags got %b want 000", timeout_flags); end
    checks++; if (ov_active_idx !== 2'd0 || ov_busy !== 1'b0) begin errors++; $display("FAIL reset_ov_idle got idx=%0d busy=%b want 0/0", ov_active_idx, ov_busy); end
    reset_n = 1'b1;
    c0 = cyc;
    run_until(c0 + 150);
    checks++; if (st_cyc.size() != 0) begin errors++; $display("FAIL idle_no_start got %0d starts want 0", st_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_frame(input bit inject_stray);
    int c0;
    logic [2:0] exp_val;
    do_reset();
    delay = '{5, 5, 5};
    c0 = cyc;
    enable = 1'b1;
    while (cyc < c0 + 125) begin
      stray_done = (inject_stray && (cyc == c0 + 50 || cyc == c0 + 103)) ? 3'b100 : 3'b000;
      if (cyc == c0 + 110) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid stray=%0d got %b want 1", inject_stray, busy); end
        checks++; if (active_idx !== 2'd1) begin errors++; $display("FAIL basic_idx_mid stray=%0d got %0d want 1", inject_stray, active_idx); end
      end
      @(negedge clk);
    end
    stray_done = '0;
    checks++; if (st_cyc.size() != 3) begin errors++; $display("FAIL basic_start_count stray=%0d got %0d want 3", inject_stray, st_cyc.size()); end
    for (int k = 0; k < 3; k++) begin
      exp_val = 3'b001 << k;
      checks++;
      if (k >= st_cyc.size() || st_cyc[k] != c0 + 101 + 6 * k) begin
        errors++;
        $display("FAIL basic_start%0d_time stray=%0d got %0d want %0d", k, inject_stray, (k < st_cyc.size()) ? st_cyc[k] - c0 : -1, 101 + 6 * k);
      end
      checks++;
      if (k >= st_val.size() || st_val[k] !== exp_val || st_idx[k] !== 2'(k)) begin
        errors++;
        $display("FAIL basic_start%0d_value stray=%0d got %b/%0d want %b/%0d", k, inject_stray, (k < st_val.size()) ? st_val[k] : 3'bxxx, (k < st_idx.size()) ? st_idx[k] : 2'bxx, exp_val, k);
      end
    end
    checks++;
    if (sn_cyc.size() != 1 || sn_cyc[0] != c0 + 119) begin
      errors++;
      $display("FAIL basic_snap stray=%0d got count=%0d first=%0d want count=1 at 119", inject_stray, sn_cyc.size(), (sn_cyc.size() > 0) ? sn_cyc[0] - c0 : -1);
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count stray=%0d got %0d want 1", inject_stray, frame_count); end
    checks++; if (overrun !== 1'b0 || timeout_flags !== 3'b000) begin errors++; $display("FAIL basic_flags stray=%0d got %b/%b want 0/000", inject_stray, overrun, timeout_flags); end
    checks++; if (busy !== 1'b0 || active_idx !== 2'd0) begin errors++; $display("FAIL basic_after got busy=%b idx=%0d want 0/0", busy, active_idx); end
  endtask

  task automatic test_watchdog();
    int c0;
    do_reset();
    delay = '{5, 0, 5};
    c0 = cyc;
    enable = 1'b1;
    run_until(c0 + 171);
    checks++; if (timeout_flags !== 3'b000 || active_idx !== 2'd1) begin errors++; $display("FAIL wd_before got flags=%b idx=%0d want 000/1", timeout_flags, active_idx); end
    run_until(c0 + 172);
    checks++; if (timeout_flags !== 3'b010) begin errors++; $display("FAIL wd_flag_set got %b want 010", timeout_flags); end
    checks++; if (step_start !== 3'b100) begin errors++; $display("FAIL wd_start2 got %b want 100", step_start); end
    run_until(c0 + 185);
    checks++;
    if (st_cyc.size() != 3 || st_cyc[2] != c0 + 172) begin
      errors++;
      $display("FAIL wd_start2_time got count=%0d last=%0d want 3 at 172", st_cyc.size(), (st_cyc.size() > 0) ? st_cyc[st_cyc.size() - 1] - c0 : -1);
    end
    checks++;
    if (sn_cyc.size() != 1 || sn_cyc[0] != c0 + 178) begin
      errors++;
      $display("FAIL wd_snap got count=%0d first=%0d want 1 at 178", sn_cyc.size(), (sn_cyc.size() > 0) ? sn_cyc[0] - c0 : -1);
    end
    checks++; if (frame_count !== 16'd1 || overrun !== 1'b0) begin errors++; $display("FAIL wd_frame got count=%0d overrun=%b want 1/0", frame_count, overrun); end
  endtask

  task automatic test_overrun();
    int c0;
    do_reset();
    c0 = cyc;
    ov_enable = 1'b1;
    run_until(c0 + 40);
    checks++; if (ov_overrun !== 1'b0) begin errors++; $display("FAIL ov_before got %b want 0", ov_overrun); end
    run_until(c0 + 41);
    checks++; if (ov_overrun !== 1'b1) begin errors++; $display("FAIL ov_set got %b want 1", ov_overrun); end
    run_until(c0 + 56);
    checks++; if (ov_frame_count !== 16'd1) begin errors++; $display("FAIL ov_count1 got %0d want 1", ov_frame_count); end
    run_until(c0 + 100);
    checks++;
    if (ov_st_cyc.size() != 2 || ov_st_cyc[0] != c0 + 21 || ov_st_cyc[1] != c0 + 61) begin
      errors++;
      $display("FAIL ov_frame_starts got count=%0d second=%0d want 2 at 21,61", ov_st_cyc.size(), (ov_st_cyc.size() > 1) ? ov_st_cyc[1] - c0 : -1);
    end
    checks++;
    if (ov_sn_cyc.size() != 2 || ov_sn_cyc[0] != c0 + 54 || ov_sn_cyc[1] != c0 + 94) begin
      errors++;
      $display("FAIL ov_snaps got count=%0d first=%0d want 2 at 54,94", ov_sn_cyc.size(), (ov_sn_cyc.size() > 0) ? ov_sn_cyc[0] - c0 : -1);
    end
    checks++; if (ov_frame_count !== 16'd2 || ov_timeout_flags !== 3'b000) begin errors++; $display("FAIL ov_count2 got %0d/%b want 2/000", ov_frame_count, ov_timeout_flags); end
  endtask

  task automatic test_enable_drop();
    int c0;
    do_reset();
    delay = '{5, 5, 5};
    c0 = cyc;
    enable = 1'b1;
    run_until(c0 + 110);
    enable = 1'b0;
    run_until(c0 + 119);
    checks++; if (snap_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL drop_snap got snap=%b busy=%b want 1/1", snap_en, busy); end
    run_until(c0 + 260);
    checks++; if (st_cyc.size() != 3 || sn_cyc.size() != 1) begin errors++; $display("FAIL drop_no_more got starts=%0d snaps=%0d want 3/1", st_cyc.size(), sn_cyc.size()); end
    checks++; if (busy !== 1'b0 || frame_count !== 16'd1) begin errors++; $display("FAIL drop_idle got busy=%b count=%0d want 0/1", busy, frame_count); end
  endtask

  task automatic test_reset_mid_run();
    int c0;
    do_reset();
    delay = '{5, 5, 5};
    c0 = cyc;
    enable = 1'b1;
    run_until(c0 + 109);
    checks++; if (active_idx !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got idx=%0d busy=%b want 1/1", active_idx, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (active_idx !== 2'd0 || busy !== 1'b0 || step_start !== 3'b000) begin errors++; $display("FAIL midrst_now got idx=%0d busy=%b start=%b want 0/0/000", active_idx, busy, step_start); end
    enable = 1'b0;
    run_until(c0 + 125);
    reset_n = 1'b1;
    run_until(c0 + 140);
    checks++; if (sn_cyc.size() != 0 || frame_count !== 16'd0) begin errors++; $display("FAIL midrst_nosnap got snaps=%0d count=%0d want 0/0", sn_cyc.size(), frame_count); end
    checks++; if (st_cyc.size() != 2 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after got starts=%0d busy=%b want 2/0", st_cyc.size(), busy); end
  endtask

  task automatic test_clear_flags();
    int c0;
    do_reset();
    delay = '{5, 0, 40};
    c0 = cyc;
    enable = 1'b1;
    while (cyc < c0 + 402) begin
      clear_flags = (cyc == c0 + 220 || cyc == c0 + 371 || cyc == c0 + 400);
      if (cyc == c0 + 220) begin
        checks++; if (overrun !== 1'b1 || timeout_flags !== 3'b010) begin errors++; $display("FAIL clr_pre got %b/%b want 1/010", overrun, timeout_flags); end
      end
      if (cyc == c0 + 221) begin
        checks++; if (overrun !== 1'b0 || timeout_flags !== 3'b000) begin errors++; $display("FAIL clr_cleared got %b/%b want 0/000", overrun, timeout_flags); end
      end
      if (cyc == c0 + 372) begin
        checks++; if (timeout_flags !== 3'b010 || overrun !== 1'b0) begin errors++; $display("FAIL clr_timeout_wins got %b/%b want 010/0", timeout_flags, overrun); end
      end
      if (cyc == c0 + 401) begin
        checks++; if (overrun !== 1'b1 || timeout_flags !== 3'b000) begin errors++; $display("FAIL clr_overrun_wins got %b/%b want 1/000", overrun, timeout_flags); end
      end
      @(negedge clk);
    end
    clear_flags = 1'b0;
    checks++;
    if (st_cyc.size() != 6 || st_cyc[3] != c0 + 301) begin
      errors++;
      $display("FAIL clr_dropped_tick got count=%0d fourth=%0d want 6 at 301", st_cyc.size(), (st_cyc.size() > 3) ? st_cyc[3] - c0 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame(1'b0);
    test_watchdog();
    test_overrun();
    test_basic_frame(1'b1);
    test_enable_drop();
    test_reset_mid_run();
    test_clear_flags();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/physics_step_scheduler.md
Name: physics_step_scheduler

Overview:
- Sequences one physics tick across N particle update engines sharing one arithmetic datapath. Starts them strictly one at a time, round-robin from index 0.
- Waits for each engine's done, then issues a one-cycle snapshot strobe so display/neighbour logic latches a consistent frame of positions.
- Sits between the top-level tick timebase and the particle array; replaces free-running phase-offset scheduling.

Parameters:
- N_PARTICLES, 3, number of particle engines sequenced.
- TICK_PERIOD, 1000000, clock cycles between physics tick starts.
- STEP_TIMEOUT, 64, max cycles to wait for step_done before forcing advance.
- IDX_W, 2, width of active_idx; must satisfy 2^IDX_W >= N_PARTICLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- clear_flags  in  1  one-cycle pulse clearing sticky flags.
- step_done  in  N_PARTICLES  per-engine completion pulse.
- step_start  out  N_PARTICLES  one-hot, one-cycle start pulse to the selected engine.
- active_idx  out  IDX_W  index of engine currently started/running.
- busy  out  1  high in START, RUN, SNAP.
- snap_en  out  1  one-cycle strobe: latch all particle outputs into the shadow frame.
- frame_count  out  16  completed frames, wraps 0xFFFF->0.
- overrun  out  1  sticky: a tick expired while not in WAIT.
- timeout_flags  out  N_PARTICLES  sticky per-engine watchdog expiry.

Behaviour:
- Reset (async assert, sync release) clears all outputs and internal counters to 0; state is IDLE.
- States: IDLE, WAIT, START, RUN, SNAP.
- IDLE:
  - tick_cnt held at 0.
  - enable=1 -> WAIT next cycle.
- tick_cnt:
  - Counts every cycle outside IDLE.
  - At TICK_PERIOD-1 it is "expiring" and wraps to 0 next cycle.
- WAIT:
  - enable=0 -> IDLE.
  - Else if tick expiring -> START with idx=0.
  - enable is sampled only in WAIT; deassert mid-frame completes the frame first.
- START:
  - step_start[idx]=1 for exactly this cycle; all other bits 0.
  - watchdog=0; -> RUN.
- RUN:
  - watchdog increments each cycle.
  - step_done[idx]=1 -> advance.
  - Else if watchdog==STEP_TIMEOUT-1: set timeout_flags[idx], then advance.
  - Advance: if idx==N_PARTICLES-1 -> SNAP, else idx+1 -> START.
  - step_done bits for other indices are ignored.
  - step_done is not sampled in START, WAIT, IDLE or SNAP.
- SNAP:
  - snap_en=1 for one cycle.
  - frame_count increments.
  - idx returns to 0; -> WAIT.
- A tick expiring in START/RUN/SNAP sets overrun and is dropped (not queued). The next frame waits for the next expiry.
- clear_flags clears overrun and timeout_flags. If a set event coincides, set wins.
- Latency:
  - tick expiry at cycle T -> step_start[0] at T+1.
  - done sampled at D -> next step_start at D+1.
  - Final done at D -> snap_en at D+1.
- Minimum frame occupancy: 2*N_PARTICLES+1 cycles (done returned one cycle after start).
- active_idx is valid in START/RUN, and holds 0 elsewhere.
- Reset mid-frame aborts immediately with no snap_en and no count increment. An engine must tolerate a missing start after reset.

Test Plan:
- Basic frame (N=3, TICK_PERIOD=100, STEP_TIMEOUT=64): enable=1; engines return done 5 cycles after start.
  - step_start = 001, 010, 100 at tick+1, +7, +13.
  - snap_en at +19; frame_count=1; no flags set.
- Watchdog: engine 1 never returns done.
  - step_start[2] fires 64 cycles after step_start[1]+1.
  - timeout_flags=010; frame still completes with snap_en.
- Overrun: TICK_PERIOD=20, engines take 10 cycles each.
  - overrun=1; second tick is dropped.
  - Next frame starts at the following expiry; frame_count increments once per completed frame.
- Stray done: pulse step_done[2] while engine 0 is running, and while in WAIT.
  - No advance occurs; the sequence matches the basic frame.
- Enable drop and reset: deassert enable during RUN of engine 1.
  - Frame completes with snap_en, then IDLE; busy=0 and no further starts.
  - Separately, assert reset_n=0 mid-RUN: all outputs 0 immediately, snap_en never pulses.
- clear_flags: with overrun=1 and timeout_flags=010, pulse clear_flags -> both 0.
  - Pulse clear_flags on the same cycle as a new timeout -> that flag reads 1.
